// File: rtl/muldiv_unit_if.sv
// Request/result bundle between decode/EX and the multiply/divide unit.
// Carries op issue, squash, MTHI/MTLO writes and the HI/LO/busy/done view.
// The master drives requests; the slave (the unit) drives status and HI/LO.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       md_op;
    logic [WIDTH-1:0] port_a;
    logic [WIDTH-1:0] port_b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdat;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, port_a, port_b, flush, hi_we, lo_we, wdat,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, md_op, port_a, port_b, flush, hi_we, lo_we, wdat,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Latency: start accepted at edge 0, done pulses in cycle WIDTH+2 with HI/LO valid.
// No backpressure: start is ignored while busy; flush aborts any op without writing HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         CLK,
    input  logic         RST,
    muldiv_unit_if.slave md
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]     b_reg;
    logic                 is_div, neg_q, neg_r;
    logic [WIDTH-1:0]     hi_reg, lo_reg;

    logic                 accept, op_signed, sign_a, sign_b;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       add_sum, sub_diff;
    logic [2*WIDTH:0]     shl;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix, quo_raw, rem_raw;

    // A new op is taken only from an idle/finishing unit and never alongside a squash.
    assign accept    = ((state == IDLE) || (state == DONE)) && md.start && !md.flush;
    assign op_signed = ~md.md_op[0];
    assign sign_a    = op_signed & md.port_a[WIDTH-1];
    assign sign_b    = op_signed & md.port_b[WIDTH-1];
    assign abs_a     = sign_a ? (~md.port_a + 1'b1) : md.port_a;
    assign abs_b     = sign_b ? (~md.port_b + 1'b1) : md.port_b;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (md.start) state_nxt = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = md.start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (md.flush) state_nxt = IDLE;
    end

    // Status outputs decoded from state.
    always_comb begin
        md.busy = (state == CALC) || (state == FIXUP);
        md.done = (state == DONE);
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_reg} : '0);
        shl      = {acc, 1'b0};
        sub_diff = shl[2*WIDTH:WIDTH] - {1'b0, b_reg};
        if (is_div) begin
            if (!sub_diff[WIDTH]) acc_nxt = {sub_diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
            else                  acc_nxt = shl[2*WIDTH-1:0];
        end else begin
            acc_nxt = {add_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the unsigned magnitude result.
    always_comb begin
        quo_raw  = acc[WIDTH-1:0];
        rem_raw  = acc[2*WIDTH-1:WIDTH];
        prod_fix = neg_q ? (~acc + 1'b1) : acc;
        quo_fix  = neg_q ? (~quo_raw + 1'b1) : quo_raw;
        rem_fix  = neg_r ? (~rem_raw + 1'b1) : rem_raw;
    end

    // Datapath and HI/LO: operand latch, iteration, result load, MTHI/MTLO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= '0;
            acc    <= '0;
            b_reg  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            if (!md.busy && md.hi_we) hi_reg <= md.wdat;
            if (!md.busy && md.lo_we) lo_reg <= md.wdat;
            if (accept) begin
                cnt    <= '0;
                acc    <= {{WIDTH{1'b0}}, abs_a};
                b_reg  <= abs_b;
                is_div <= md.md_op[1];
                // A zero divisor yields an all-ones quotient regardless of signs.
                neg_q  <= (sign_a ^ sign_b) && !(md.md_op[1] && (md.port_b == '0));
                neg_r  <= sign_a;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                acc <= acc_nxt;
            end else if ((state == FIXUP) && !md.flush) begin
                if (is_div) begin
                    hi_reg <= rem_fix;
                    lo_reg <= quo_fix;
                end else begin
                    {hi_reg, lo_reg} <= prod_fix;
                end
            end
        end
    end

    assign md.hi = hi_reg;
    assign md.lo = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded random/directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   fails   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) mif ();
    muldiv_unit #(.WIDTH(32)) dut (.CLK(clk), .RST(rst), .md(mif.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else        p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && mif.done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check("result_hi", mif.hi, e[63:32]);
                check("result_lo", mif.lo, e[31:0]);
            end
        end
    end

    // Drive a start for one cycle (called at a negedge); returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
        mif.start  = 1'b1;
        mif.md_op  = op;
        mif.port_a = a;
        mif.port_b = b;
        if (expect_result) exp_q.push_back(model(op, a, b));
        @(negedge clk);
        mif.start = 1'b0;
        mif.hi_we = 1'b0;
        mif.lo_we = 1'b0;
        mif.port_a = $urandom;
        mif.port_b = $urandom;
        mif.md_op  = 2'($urandom_range(0, 3));
    endtask

    // Wait for done with a bounded budget and check the fixed latency.
    task automatic wait_done();
        int n = 1;
        while (!mif.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd34);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b, 1'b1);
        wait_done();
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1;
        mif.start = 0; mif.md_op = 0; mif.port_a = 0; mif.port_b = 0;
        mif.flush = 0; mif.hi_we = 0; mif.lo_we = 0; mif.wdat = 0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(mif.busy), 32'd0);
        check("reset_done", 32'(mif.done), 32'd0);
        check("reset_hi", mif.hi, 32'd0);
        check("reset_lo", mif.lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases, issued back to back from the DONE cycle.
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'b00, 32'hFFFF_FFFD, 32'd7);
        run(2'b00, 32'h8000_0000, 32'h8000_0000);
        run(2'b10, 32'hFFFF_FFF9, 32'd2);
        run(2'b11, 32'd100, 32'd7);
        run(2'b10, 32'h1234_5678, 32'd0);
        run(2'b10, 32'hFFFF_FFF0, 32'd0);
        run(2'b11, 32'h8765_4321, 32'd0);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);

        // MTHI together with start: write lands first, result overwrites later.
        mif.hi_we = 1'b1;
        mif.wdat  = 32'h0000_AAAA;
        issue(2'b11, 32'd1000, 32'd3, 1'b1);
        check("mthi_with_start", mif.hi, 32'h0000_AAAA);
        wait_done();
        @(negedge clk);

        // Preload HI/LO, then abort a MULTU; ignored start and MTHI while busy.
        mif.hi_we = 1'b1; mif.lo_we = 1'b1; mif.wdat = 32'd5;
        @(negedge clk);
        mif.hi_we = 1'b0; mif.lo_we = 1'b0;
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (4) @(negedge clk);
        mif.start = 1'b1; mif.md_op = 2'b11; mif.hi_we = 1'b1; mif.wdat = 32'd99;
        @(negedge clk);
        mif.start = 1'b0; mif.hi_we = 1'b0;
        repeat (4) @(negedge clk);
        mif.flush = 1'b1;
        mif.start = 1'b1;
        @(negedge clk);
        mif.flush = 1'b0;
        mif.start = 1'b0;
        check("flush_busy", 32'(mif.busy), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_hi", mif.hi, 32'd5);
        check("flush_lo", mif.lo, 32'd5);

        // Flush and start together from IDLE: start is dropped.
        mif.flush = 1'b1;
        issue(2'b00, 32'd3, 32'd3, 1'b0);
        mif.flush = 1'b0;
        check("flush_start_busy", 32'(mif.busy), 32'd0);

        // Reset in the middle of a DIVU.
        issue(2'b11, 32'hDEAD_BEEF, 32'd13, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(mif.busy), 32'd0);
        check("rst_mid_done", 32'(mif.done), 32'd0);
        check("rst_mid_hi", mif.hi, 32'd0);
        check("rst_mid_lo", mif.lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Random operations with corner-biased operands.
        for (int i = 0; i < 30; i++) begin
            ra = pick();
            rb = pick();
            if (i % 7 == 3) rb = 32'd0;
            if (i % 5 == 2) repeat ($urandom_range(1, 3)) @(negedge clk);
            run(2'($urandom_range(0, 3)), ra, rb);
        end
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
